cnt_event_feeder: RTL and testbench

Upstream stage of the counter block. Collects single-cycle event pulses from several sources, holds them in a saturating backlog and drains the backlog into the counter's `inc`/`en` inputs at up to 2^CNT_INPUT_SIZE−1 events per cycle. It also sequences a clean counter clear, flushing the backlog first and then pulsing `clear`, acknowledged to the requester.

---
 rtl/cnt_pkg.sv | 16 +
 rtl/cnt_popcount.sv | 19 +
 rtl/cnt_event_feeder.sv | 113 +++++++++++
 tb/tb_cnt_event_feeder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared types and helpers for the counter block: feeder FSM states and increment limits.
// Imported by the feeder, the counter and the downstream monitors.
package cnt_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        CLEAR = 2'd2
    } feed_state_t;

    // Largest value an unsigned field of the given width can hold.
    function automatic int max_inc(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/cnt_popcount.sv
// Combinational count of set bits in the event vector; zero latency, no flow control.
// Output is wide enough to hold NUM_SRC.
module cnt_popcount #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]              bits,
    output logic [$clog2(NUM_SRC+1)-1:0]    count
);

    localparam int CW = $clog2(NUM_SRC + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/cnt_event_feeder.sv
// Event backlog feeding the counter: 2-cycle event-to-inc latency, up to MAX_INC per cycle.
// pause halts draining while events keep accumulating; overflow saturates and sets drop_err.
module cnt_event_feeder
    import cnt_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int CNT_INPUT_SIZE = 2,
    parameter int PEND_SIZE      = 6
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [NUM_SRC-1:0]        ev,
    input  logic                      pause,
    input  logic                      clr_req,
    output logic                      clr_ack,
    output logic                      clear,
    output logic                      en,
    output logic [CNT_INPUT_SIZE-1:0] inc,
    output logic [PEND_SIZE-1:0]      pend_level,
    output logic                      drop_err
);

    localparam int CW       = $clog2(NUM_SRC + 1);
    localparam int MAX_INC  = max_inc(CNT_INPUT_SIZE);
    localparam int PEND_MAX = max_inc(PEND_SIZE);

    localparam logic [PEND_SIZE:0]        MAX_INC_W  = (PEND_SIZE+1)'(MAX_INC);
    localparam logic [PEND_SIZE:0]        PEND_MAX_W = (PEND_SIZE+1)'(PEND_MAX);
    localparam logic [CNT_INPUT_SIZE-1:0] MAX_INC_D  = CNT_INPUT_SIZE'(MAX_INC);

    feed_state_t                state, state_next;
    logic [PEND_SIZE-1:0]       pend, pend_next;
    logic [CW-1:0]              ev_cnt;
    logic [CW-1:0]              add;
    logic [CNT_INPUT_SIZE-1:0]  drain;
    logic [PEND_SIZE:0]         sum;
    logic                       sat;
    logic                       drop;
    logic                       enter_clear;

    cnt_popcount #(.NUM_SRC(NUM_SRC)) u_popcount (
        .bits  (ev),
        .count (ev_cnt)
    );

    always_comb begin
        drain = '0;
        if (!pause) begin
            if ({1'b0, pend} > MAX_INC_W) begin
                drain = MAX_INC_D;
            end else begin
                drain = pend[CNT_INPUT_SIZE-1:0];
            end
        end
    end

    assign add = (state == RUN) ? ev_cnt : '0;
    assign sum = {1'b0, pend} - (PEND_SIZE+1)'(drain) + (PEND_SIZE+1)'(add);
    assign sat = (sum > PEND_MAX_W);
    assign pend_next = sat ? PEND_MAX_W[PEND_SIZE-1:0] : sum[PEND_SIZE-1:0];
    assign drop = sat || ((state != RUN) && (|ev));

    // Leave FLUSH only once the backlog reads empty, i.e. one cycle after the
    // final drain was registered, so clear never coincides with en.
    always_comb begin
        state_next  = state;
        enter_clear = 1'b0;
        case (state)
            RUN: begin
                if (clr_req) state_next = FLUSH;
            end
            FLUSH: begin
                if ((pend == '0) && !pause) begin
                    state_next  = CLEAR;
                    enter_clear = 1'b1;
                end
            end
            CLEAR: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= RUN;
            pend     <= '0;
            inc      <= '0;
            en       <= 1'b0;
            clear    <= 1'b0;
            clr_ack  <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            state   <= state_next;
            pend    <= pend_next;
            inc     <= drain;
            en      <= |drain;
            clear   <= enter_clear;
            clr_ack <= enter_clear;
            if (drop) begin
                drop_err <= 1'b1;
            end else if (enter_clear) begin
                drop_err <= 1'b0;
            end
        end
    end

    assign pend_level = pend;

endmodule

// File: tb/tb_cnt_event_feeder.sv
// Directed bench for cnt_event_feeder: cycle model compared every cycle plus literal checkpoints.
module tb_cnt_event_feeder;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] ev = 4'b0;
    logic       pause = 1'b0;
    logic       clr_req = 1'b0;
    logic       clr_ack, clear, en, drop_err;
    logic [1:0] inc;
    logic [5:0] pend_level;

    int n_chk = 0;
    int n_fail = 0;

    localparam int M_RUN = 0, M_FLUSH = 1, M_CLEAR = 2;

    // Model: backlog as a plain integer, mode as an integer tag.
    int m_pend = 0, m_mode = M_RUN;
    int e_inc = 0, e_en = 0, e_clear = 0, e_ack = 0, e_drop = 0;

    // Observed totals
    int delivered = 0, acks = 0, clears = 0;

    cnt_event_feeder #(
        .NUM_SRC        (4),
        .CNT_INPUT_SIZE (2),
        .PEND_SIZE      (6)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .ev         (ev),
        .pause      (pause),
        .clr_req    (clr_req),
        .clr_ack    (clr_ack),
        .clear      (clear),
        .en         (en),
        .inc        (inc),
        .pend_level (pend_level),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_L) begin
        int drain, total;
        bit lost, to_clear;
        if (!reset_L) begin
            m_pend = 0; m_mode = M_RUN;
            e_inc = 0; e_en = 0; e_clear = 0; e_ack = 0; e_drop = 0;
        end else begin
            drain = pause ? 0 : ((m_pend < 3) ? m_pend : 3);
            lost  = 1'b0;
            total = m_pend - drain;
            if (m_mode == M_RUN) total += $countones(ev);
            else if (ev != 4'b0) lost = 1'b1;
            if (total > 63) begin
                total = 63;
                lost  = 1'b1;
            end
            to_clear = (m_mode == M_FLUSH) && (m_pend == 0) && !pause;
            e_inc   = drain;
            e_en    = (drain != 0) ? 1 : 0;
            e_clear = to_clear ? 1 : 0;
            e_ack   = to_clear ? 1 : 0;
            if (lost) e_drop = 1;
            else if (to_clear) e_drop = 0;
            case (m_mode)
                M_RUN:   if (clr_req) m_mode = M_FLUSH;
                M_FLUSH: if (to_clear) m_mode = M_CLEAR;
                default: m_mode = M_RUN;
            endcase
            m_pend = total;
        end
    end

    always @(negedge clk) begin
        chk("pend_level", int'(pend_level), m_pend);
        chk("inc",        int'(inc),        e_inc);
        chk("en",         int'(en),         e_en);
        chk("clear",      int'(clear),      e_clear);
        chk("clr_ack",    int'(clr_ack),    e_ack);
        chk("drop_err",   int'(drop_err),   e_drop);
        if (reset_L) begin
            if (en) delivered += int'(inc);
            if (clr_ack) acks++;
            if (clear) clears++;
        end
    end

    // Apply one cycle of inputs; returns 2 time units after the sampling edge.
    task automatic tick(input logic [3:0] e, input logic p, input logic c);
        ev = e; pause = p; clr_req = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n3, nen, d0, a0, c0;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_pend", int'(pend_level), 0);
        chk("reset_en",   int'(en),         0);
        chk("reset_drop", int'(drop_err),   0);
        reset_L = 1'b1;

        // Single event: backlog at t+1, counter inputs at t+2
        tick(4'b0001, 0, 0);
        chk("t1_pend1", int'(pend_level), 1);
        chk("t1_en_early", int'(en), 0);
        tick(4'b0000, 0, 0);
        chk("t1_inc", int'(inc), 1);
        chk("t1_en",  int'(en),  1);
        tick(4'b0000, 0, 0);
        chk("t1_idle_en", int'(en), 0);

        // Three full-width bursts
        d0 = delivered; n3 = 0;
        tick(4'b1111, 0, 0); chk("t2_pend_a", int'(pend_level), 4);
        if (en && inc == 2'd3) n3++;
        tick(4'b1111, 0, 0); chk("t2_pend_b", int'(pend_level), 5);
        if (en && inc == 2'd3) n3++;
        tick(4'b1111, 0, 0); chk("t2_pend_c", int'(pend_level), 6);
        if (en && inc == 2'd3) n3++;
        for (int i = 0; i < 4; i++) begin
            tick(4'b0000, 0, 0);
            if (en && inc == 2'd3) n3++;
        end
        chk("t2_inc3_cycles", n3, 4);
        chk("t2_delivered", delivered - d0, 12);

        // Paused saturation
        nen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(4'b1111, 1, 0);
            if (en) nen++;
        end
        chk("t3_pend_sat", int'(pend_level), 63);
        chk("t3_drop", int'(drop_err), 1);
        chk("t3_en_paused", nen, 0);
        d0 = delivered; n3 = 0;
        for (int i = 0; i < 25; i++) begin
            tick(4'b0000, 0, 0);
            if (en && inc == 2'd3) n3++;
        end
        chk("t3_inc3_cycles", n3, 21);
        chk("t3_delivered", delivered - d0, 63);

        // Clear with backlog of 7
        tick(4'b1111, 1, 0);
        tick(4'b0111, 1, 0);
        chk("t4_pend7", int'(pend_level), 7);
        tick(4'b0000, 1, 1);
        chk("t4_flush_pend", int'(pend_level), 7);
        tick(4'b0000, 0, 0); chk("t4_inc_a", int'(inc), 3);
        tick(4'b0000, 0, 0); chk("t4_inc_b", int'(inc), 3);
        tick(4'b0000, 0, 0); chk("t4_inc_c", int'(inc), 1);
        chk("t4_clear_early", int'(clear), 0);
        tick(4'b0000, 0, 0);
        chk("t4_clear", int'(clear), 1);
        chk("t4_ack", int'(clr_ack), 1);
        chk("t4_en_with_clear", int'(en), 0);
        chk("t4_drop_cleared", int'(drop_err), 0);
        tick(4'b0000, 0, 0);
        chk("t4_clear_pulse", int'(clear), 0);

        // Events during FLUSH and a clr_req during CLEAR
        a0 = acks;
        tick(4'b0111, 1, 0);
        tick(4'b0000, 0, 1);
        chk("t5_inc", int'(inc), 3);
        tick(4'b0010, 1, 0);
        chk("t5_drop_flush", int'(drop_err), 1);
        tick(4'b0001, 0, 0);
        chk("t5_clear", int'(clear), 1);
        chk("t5_drop_wins", int'(drop_err), 1);
        tick(4'b0100, 0, 1);
        for (int i = 0; i < 4; i++) tick(4'b0000, 0, 0);
        chk("t5_acks", acks - a0, 1);
        chk("t5_drop_after", int'(drop_err), 1);
        chk("t5_pend", int'(pend_level), 0);

        // Reset in the middle of a flush
        tick(4'b1111, 1, 0);
        tick(4'b1111, 1, 0);
        tick(4'b0011, 1, 0);
        chk("t6_pend10", int'(pend_level), 10);
        tick(4'b0000, 1, 1);
        tick(4'b0000, 0, 0);
        chk("t6_inc", int'(inc), 3);
        reset_L = 1'b0;
        #1;
        chk("t6_rst_pend", int'(pend_level), 0);
        chk("t6_rst_en",   int'(en),         0);
        chk("t6_rst_inc",  int'(inc),        0);
        chk("t6_rst_drop", int'(drop_err),   0);
        c0 = clears; a0 = acks;
        tick(4'b0000, 0, 0);
        tick(4'b0000, 0, 0);
        reset_L = 1'b1;
        for (int i = 0; i < 6; i++) tick(4'b0000, 0, 0);
        chk("t6_no_clear", clears - c0, 0);
        chk("t6_no_ack", acks - a0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
